// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction prefetcher.
package ifetch_pkg;

  // Prefetcher control states.
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  localparam int unsigned InstW = 32;
  localparam int unsigned PcInc = 4;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: registered FIFO with synchronous flush and occupancy output.
// Flush beats any same-cycle push or pop.
module ifetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Guard against popping empty / pushing full; a pop frees a slot for a push.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CntW'(DEPTH)) || do_pop);
  end

  // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: issues sequential word fetches, buffers in-order
// responses for decode and discards stale responses after a redirect.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req_valid,
  output logic [ADDR_W-1:0]       imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_rsp_valid,
  input  logic [InstW-1:0]        imem_rsp_data,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    if_valid,
  output logic [ADDR_W-1:0]       if_pc,
  output logic [InstW-1:0]        if_inst,
  input  logic                    if_ready,
  output logic [$clog2(DEPTH):0]  buf_count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned SumW = CntW + 1;
  localparam int unsigned EntW = ADDR_W + InstW;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]   outst_q, outst_d;
  logic [CntW-1:0]   drop_q, drop_d;

  logic [SumW-1:0]   occ_sum;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              req_fire, rsp_drop;
  logic              fifo_push, fifo_pop, fifo_flush;
  logic [EntW-1:0]   fifo_rdata;

  // Next-state, request gating and buffer control.
  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    rsp_pc_d         = rsp_pc_q;
    drop_d           = drop_q;
    redirect_aligned = redirect_pc & ~ADDR_W'(3);

    // Outstanding includes requests whose responses will be dropped, so the
    // buffer can never overflow regardless of drop state.
    occ_sum        = {1'b0, buf_count} + {1'b0, outst_q};
    imem_req_valid = (state_q != IDLE) && (occ_sum < SumW'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_drop       = (drop_q != '0);
    outst_d        = outst_q + CntW'(req_fire) - CntW'(imem_rsp_valid);

    fifo_pop   = if_valid && if_ready;
    fifo_flush = redirect_valid;
    fifo_push  = imem_rsp_valid && !rsp_drop && !redirect_valid;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PcInc);
    end
    if (fifo_push) begin
      rsp_pc_d = rsp_pc_q + ADDR_W'(PcInc);
    end
    if (imem_rsp_valid && rsp_drop) begin
      drop_d = drop_q - 1'b1;
    end

    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      DRAIN:   if (drop_d == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    // Everything still in flight after this cycle belongs to the old stream.
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      drop_d     = outst_d;
      if (state_q != IDLE) begin
        state_d = (outst_d != '0) ? DRAIN : FETCH;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata ({rsp_pc_q, imem_rsp_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (buf_count)
  );

  // Buffer head drives decode directly.
  always_comb begin
    imem_req_addr     = fetch_pc_q;
    if_valid          = (buf_count != '0);
    {if_pc, if_inst}  = fifo_rdata;
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Randomized + directed bench for ifetch_prefetch against a stream-level model:
// decode must see consecutive PCs from the last redirect target, each paired
// with its ROM word, with occupancy = live responses received - instructions taken.
module tb_ifetch_prefetch;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic [2:0]  buf_count;

  ifetch_prefetch #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_ready       (if_ready),
    .buf_count      (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    int unsigned epoch;
  } mem_t;

  mem_t        memq[$];
  logic [31:0] acc_addrs[$];
  logic [31:0] pop_pcs[$];
  int unsigned cyc, epoch, last_due;
  logic [31:0] exp_pc, exp_fetch;
  int          model_cnt, since_rst, req_cnt, stale_cnt;
  bit          prev_live, prev_redir;
  int          n_checks, n_err;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00a00093;
      32'h4:   return 32'h01400113;
      32'h8:   return 32'h002081b3;
      default: return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: entered and left at #1 after a rising edge.
  task automatic step(input bit rdir, input logic [31:0] tgt, input bit rq_rdy,
                      input bit ifr, input int unsigned lat);
    bit          live;
    bit          fire;
    bit          popped;
    int          outstanding;
    mem_t        m;
    int unsigned due;
    redirect_valid = rdir;
    redirect_pc    = tgt;
    imem_req_ready = rq_rdy;
    if_ready       = ifr;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    outstanding = memq.size();
    check("req_valid", imem_req_valid,
          (since_rst > 0) && (model_cnt + outstanding < int'(DEPTH)));
    check("buf_count", buf_count, model_cnt);
    check("if_valid", if_valid, model_cnt != 0);
    if (prev_redir) check("if_valid_after_redirect", if_valid, 1'b0);
    else if (prev_live) check("if_valid_latency", if_valid, 1'b1);
    fire   = imem_req_valid && rq_rdy;
    popped = if_valid && ifr;
    if (fire) begin
      check("req_addr", imem_req_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{due: due, data: rom(imem_req_addr), epoch: epoch});
      acc_addrs.push_back(imem_req_addr);
      req_cnt++;
    end
    if (popped) begin
      check("if_pc", if_pc, exp_pc);
      check("if_inst", if_inst, rom(exp_pc));
      pop_pcs.push_back(if_pc);
      exp_pc = exp_pc + 32'd4;
      model_cnt--;
    end
    live = 1'b0;
    if (imem_rsp_valid) begin
      m = memq.pop_front();
      if (m.epoch == epoch) begin
        model_cnt++;
        live = 1'b1;
      end else begin
        stale_cnt++;
      end
    end
    if (rdir) begin
      epoch++;
      model_cnt = 0;
      live      = 1'b0;
      exp_pc    = {tgt[31:2], 2'b00};
      exp_fetch = {tgt[31:2], 2'b00};
    end
    prev_live  = live;
    prev_redir = rdir;
    since_rst++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Two cycles of reset with output checks; memory model is cleared too.
  task automatic do_reset();
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    memq.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_req_valid", imem_req_valid, 1'b0);
      check("rst_if_valid", if_valid, 1'b0);
      check("rst_buf_count", buf_count, 3'd0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_inst", if_inst, 32'h0);
      @(posedge clk);
      #1;
      cyc++;
    end
    rst        = 1'b0;
    model_cnt  = 0;
    exp_pc     = RESET_PC;
    exp_fetch  = RESET_PC;
    since_rst  = 0;
    prev_live  = 1'b0;
    prev_redir = 1'b0;
    last_due   = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    epoch    = 0;
    last_due = 0;
    req_cnt  = 0;
    stale_cnt = 0;
    do_reset();

    // Sequential fetch, 1-cycle memory, decode always ready.
    pop_pcs.delete();
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    check("seq_pop_count", pop_pcs.size(), 9);
    if (pop_pcs.size() >= 3) begin
      check("seq_pc0", pop_pcs[0], 32'h0);
      check("seq_pc1", pop_pcs[1], 32'h4);
      check("seq_pc2", pop_pcs[2], 32'h8);
    end

    // Backpressure: decode stalled fills exactly DEPTH entries.
    do_reset();
    req_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    check("bp_buf_count", buf_count, 3'd4);
    check("bp_req_valid", imem_req_valid, 1'b0);
    check("bp_req_count", req_cnt, 4);

    // Redirect with two requests in flight, 3-cycle memory.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 3);
    check("rd_inflight", memq.size(), 2);
    stale_cnt = 0;
    pop_pcs.delete();
    step(1'b1, 32'h1C, 1'b0, 1'b1, 3);
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 3);
    check("rd_dropped", stale_cnt, 2);
    if (pop_pcs.size() > 0) check("rd_first_pc", pop_pcs[0], 32'h1C);
    else check("rd_first_pc_seen", 0, 1);

    // Misaligned redirect near the top of the address space.
    step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1);
    acc_addrs.delete();
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    if (acc_addrs.size() >= 2) begin
      check("wrap_addr0", acc_addrs[0], 32'hFFFF_FFFC);
      check("wrap_addr1", acc_addrs[1], 32'h0000_0000);
    end else check("wrap_addr_count", acc_addrs.size(), 2);

    // Redirect, pop and live response in the same cycle.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (model_cnt > 0 && memq.size() > 0 && memq[0].due <= cyc && memq[0].epoch == epoch)
        found = 1'b1;
      else step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    end
    check("sim_setup", found, 1'b1);
    step(1'b1, 32'h40, 1'b1, 1'b1, 1);
    check("sim_buf_count", buf_count, 3'd0);
    check("sim_if_valid", if_valid, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);

    // Reset while three entries are buffered.
    for (int i = 0; i < 20 && model_cnt != 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    check("mid_fill3", buf_count, 3'd3);
    do_reset();
    acc_addrs.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    if (acc_addrs.size() > 0) check("mid_first_addr", acc_addrs[0], RESET_PC);
    else check("mid_first_addr_seen", 0, 1);

    // Random traffic: latency, readiness and redirects all vary.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
      step($urandom_range(0, 99) < 4, tgt, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 60, $urandom_range(1, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 Parameter ADDR_W, default 32, sets the PC/address width in bits.
REQ-002 Parameter DEPTH, default 4, sets the prefetch buffer entries; it SHALL be a power of 2 and at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_addr  output  ADDR_W  word-aligned fetch address.
REQ-008 imem_req_ready  input  1  memory accepts request this cycle.
REQ-009 imem_rsp_valid  input  1  in-order response data valid.
REQ-010 imem_rsp_data  input  32  instruction word.
REQ-011 redirect_valid  input  1  branch/jump redirect strobe.
REQ-012 redirect_pc  input  ADDR_W  redirect target.
REQ-013 if_valid  output  1  decode-side instruction valid.
REQ-014 if_pc  output  ADDR_W  PC of if_inst.
REQ-015 if_inst  output  32  instruction to decode.
REQ-016 if_ready  input  1  decode accepts instruction.
REQ-017 buf_count  output  clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-018 A request SHALL transfer when imem_req_valid and imem_req_ready are both high; a response SHALL transfer when imem_rsp_valid is high, with no backpressure.
REQ-019 imem_req_valid SHALL be high in state FETCH iff (buf_count + outstanding) < DEPTH, where outstanding counts accepted requests not yet responded to, including requests marked for drop.
REQ-020 imem_req_addr SHALL equal fetch_pc; fetch_pc SHALL advance by 4 per accepted request, wrapping modulo 2^ADDR_W.
REQ-021 imem_req_addr, imem_req_valid, if_pc, if_inst and if_valid SHALL remain stable while valid is high and ready is low.
REQ-022 Each non-dropped response SHALL be written to the buffer with PC rsp_pc, which SHALL then advance by 4, wrapping.
REQ-023 The buffer head SHALL drive if_valid, if_pc and if_inst combinationally; an entry pops when if_valid and if_ready are both high; a push and a pop in the same cycle SHALL leave buf_count unchanged.
REQ-024 Latency: a response in cycle N SHALL make if_valid high in cycle N+1 (registered buffer, no bypass).
REQ-025 A redirect in cycle N SHALL, at the end of that cycle: flush the buffer; set fetch_pc and rsp_pc to redirect_pc with bits[1:0] forced to 0; set drop_cnt to outstanding (including any request accepted in cycle N), minus one if a response also arrives in cycle N.
REQ-026 The redirect SHALL take priority over a same-cycle pop and push, so that the popped or pushed entry is discarded.
REQ-027 While drop_cnt > 0, each response SHALL be discarded and SHALL decrement drop_cnt; new requests MAY issue subject to REQ-019.
REQ-028 if_valid SHALL be low in cycle N+1 after a redirect in cycle N.
REQ-029 The FSM SHALL have three states:
- IDLE: entered at reset; moves to FETCH after one cycle with no requests issued.
- FETCH: entered from IDLE, or from DRAIN when drop_cnt reaches 0.
- DRAIN: entered from FETCH or DRAIN on a redirect with nonzero drop; behaviour otherwise equals FETCH.
REQ-030 A redirect during IDLE SHALL update fetch_pc and rsp_pc, and the transition to FETCH SHALL still occur.

Reset
REQ-031 While rst is high, the block SHALL hold these values:
- imem_req_valid=0, if_valid=0, buf_count=0.
- outstanding=0, drop_cnt=0, state=IDLE.
- fetch_pc=rsp_pc=RESET_PC; if_pc and if_inst equal 0.
REQ-032 Reset asserted mid-transaction SHALL abandon all in-flight requests; the memory model is reset together with the block.

Structure
REQ-033 Package ifetch_pkg SHALL hold the FSM state enum (IDLE, FETCH, DRAIN), the instruction width constant 32 and the PC increment constant 4.
REQ-034 The buffer SHALL be one sub-module, ifetch_fifo (DEPTH x (ADDR_W+32), synchronous flush input, count output); all other logic SHALL be in ifetch_prefetch.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Sequential fetch. ROM holds 0x00a00093, 0x01400113, 0x002081b3 at 0x0, 0x4, 0x8; memory is always ready with 1-cycle response; if_ready=1 -> if_pc/if_inst sequence 0x0/0x00a00093, 0x4/0x01400113, 0x8/0x002081b3 with no gaps after fill.
- Backpressure. if_ready=0 with DEPTH=4 -> buf_count reaches 4, imem_req_valid stays low, and exactly 4 requests are issued.
- Redirect with in-flight requests. Memory latency is 3 cycles; redirect_pc=0x1C is applied with 2 requests outstanding -> 2 responses are dropped, and the first if_pc after the redirect is 0x1C.
- Misaligned wrap. redirect_pc=0xFFFF_FFFE -> fetch addresses 0xFFFF_FFFC then 0x0000_0000.
- Simultaneous events. Redirect, pop and response all occur in the same cycle -> none of them is visible on the output, and buf_count=0 in the next cycle.
- Reset mid-run. rst is asserted for 2 cycles while 3 entries are buffered -> all outputs return to reset values, and the first request after release uses address RESET_PC.
